const_poly_gen: RTL

Parametrised generator for the constant polynomials used by the SNTRUP datapath: the all-ones vector, the reduction modulus x^P − x − 1, the unit polynomial and the zero polynomial. It streams coefficients over a valid/ready interface, one coefficient per accepted beat, into the multiplier and inversion memories. It replaces fixed combinational lookups, which support only a single pattern and length. An optional registered random-access port serves single-coefficient lookups.

---
 rtl/const_poly_pkg.sv | 23 ++
 rtl/const_poly_coef.sv | 38 +++
 rtl/const_poly_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/const_poly_pkg.sv
// Shared types and default sizing for the SNTRUP constant polynomial generator.
// Pattern selectors, FSM state constants and the default P/Q/width parameters live here.
package const_poly_pkg;

  localparam int DEF_P      = 761;
  localparam int DEF_Q      = 4591;
  localparam int DEF_COEF_W = 13;
  localparam int DEF_IDX_W  = 11;

  typedef enum logic [1:0] {
    MODE_ONES    = 2'd0,
    MODE_MODULUS = 2'd1,
    MODE_UNIT    = 2'd2,
    MODE_ZERO    = 2'd3
  } mode_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STREAM = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/const_poly_coef.sv
// Combinational coefficient lookup: (pattern, index) -> coefficient of that constant polynomial.
// Indices beyond P always map to zero.
module const_poly_coef
  import const_poly_pkg::*;
#(
  parameter int P      = DEF_P,
  parameter int Q      = DEF_Q,
  parameter int COEF_W = DEF_COEF_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  mode_e              mode,
  input  logic [IDX_W-1:0]   index,
  output logic [COEF_W-1:0]  coef
);

  localparam logic [COEF_W-1:0] MINUS_ONE = COEF_W'(Q - 1);
  localparam logic [COEF_W-1:0] PLUS_ONE  = COEF_W'(1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(P);

  // x^P - x - 1 has -1 at the two lowest terms and +1 at the top term.
  always_comb begin
    coef = '0;
    if (index <= LAST_IDX) begin
      case (mode)
        MODE_ONES:    coef = PLUS_ONE;
        MODE_MODULUS: begin
          if (index <= IDX_W'(1))
            coef = MINUS_ONE;
          else if (index == LAST_IDX)
            coef = PLUS_ONE;
        end
        MODE_UNIT:    if (index == '0) coef = PLUS_ONE;
        default:      coef = '0;
      endcase
    end
  end

endmodule

// File: rtl/const_poly_gen.sv
// Streams the coefficients 0..P of a selected constant polynomial over valid/ready.
// Optional registered random-access lookup is built when CONST_POLY_RA_EN is defined.
module const_poly_gen
  import const_poly_pkg::*;
#(
  parameter int P      = DEF_P,
  parameter int Q      = DEF_Q,
  parameter int COEF_W = DEF_COEF_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               abort,
  input  logic               out_ready,
`ifdef CONST_POLY_RA_EN
  input  logic [IDX_W-1:0]   ra_index,
  output logic [COEF_W-1:0]  ra_data,
`endif
  output logic               out_valid,
  output logic [COEF_W-1:0]  out_data,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P);

  state_t             state;
  mode_e              mode_q;
  logic               handshake;
  logic [IDX_W-1:0]   next_index;
  mode_e              coef_mode;
  logic [IDX_W-1:0]   coef_index;
  logic [COEF_W-1:0]  coef;

  assign handshake  = out_valid && out_ready;
  assign next_index = out_index + IDX_W'(1);

  // In IDLE the lookup is pointed at index 0 of the incoming mode so the first beat is ready one cycle after start.
  always_comb begin
    coef_mode  = mode_q;
    coef_index = next_index;
    if (state == ST_IDLE) begin
      coef_mode  = mode_e'(mode);
      coef_index = '0;
    end
  end

  const_poly_coef #(
    .P      (P),
    .Q      (Q),
    .COEF_W (COEF_W),
    .IDX_W  (IDX_W)
  ) u_stream_coef (
    .mode   (coef_mode),
    .index  (coef_index),
    .coef   (coef)
  );

  // out_index doubles as the beat counter; abort takes priority over any handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_ONES;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_STREAM;
            mode_q    <= mode_e'(mode);
            out_valid <= 1'b1;
            out_data  <= coef;
            out_index <= '0;
            out_last  <= (LAST_IDX == '0);
            busy      <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (abort) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
          end else if (handshake) begin
            if (out_last) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_index <= '0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_data  <= coef;
              out_index <= next_index;
              out_last  <= (next_index == LAST_IDX);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONST_POLY_RA_EN
  logic [COEF_W-1:0] ra_coef;

  const_poly_coef #(
    .P      (P),
    .Q      (Q),
    .COEF_W (COEF_W),
    .IDX_W  (IDX_W)
  ) u_ra_coef (
    .mode   (mode_q),
    .index  (ra_index),
    .coef   (ra_coef)
  );

  // Lookup runs against the latched mode regardless of stream state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ra_data <= '0;
    else
      ra_data <= ra_coef;
  end
`else
`endif

endmodule
